// File: rtl/serial_byte_receiver_pkg.sv
// Shared constants for the serial byte link (transmitter and receiver sides).
package serial_byte_receiver_pkg;
  localparam int BYTE_W    = 8;
  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int BITCNT_W  = 3;
  // Bit i of a byte travels on the i-th serial slot when set.
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/rx_byte_store.sv
// DEPTH x WIDTH register file: one write port, one registered read port.
module rx_byte_store #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read samples the pre-write contents, so a same-address read/write returns old data.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial-to-byte receiver: assembles bits into bytes and logs them into a small store.
module serial_byte_receiver
  import serial_byte_receiver_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int DEPTH = MEM_DEPTH,
  parameter int WRAP  = 0,
  localparam int AW    = (DEPTH == MEM_DEPTH) ? ADDR_W : $clog2(DEPTH),
  localparam int CNT_W = (WIDTH == BYTE_W) ? BITCNT_W : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             sync,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  output logic [AW-1:0]    wr_addr,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] assembled;
  logic             byte_done;
  logic             we;

  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] idx);
    return LSB_FIRST ? idx : CNT_W'(WIDTH - 1) - idx;
  endfunction

  // Current bit merged into the partial byte; on the last bit this is the whole byte.
  always_comb begin
    assembled = shreg;
    assembled[bit_pos(bit_cnt)] = serial_in;
  end

  assign byte_done = bit_en && !sync && (bit_cnt == CNT_W'(WIDTH - 1));
  assign full      = (count == (AW + 1)'(DEPTH));
  assign we        = byte_done && (!full || (WRAP != 0));

  always_ff @(posedge clk) begin
    if (clear) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      wr_addr    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sync) begin
        // Realign: drop the partial byte; a concurrent bit becomes bit 0.
        shreg <= '0;
        if (bit_en) begin
          shreg[bit_pos('0)] <= serial_in;
          bit_cnt            <= CNT_W'(1);
        end else begin
          bit_cnt <= '0;
        end
      end else if (bit_en) begin
        shreg   <= assembled;
        bit_cnt <= (bit_cnt == CNT_W'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
        if (byte_done) begin
          byte_out   <= assembled;
          byte_valid <= 1'b1;
          if (we) begin
            wr_addr <= (wr_addr == AW'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
            if (!full) count <= count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  rx_byte_store #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .clear (clear),
    .we    (we),
    .waddr (wr_addr),
    .wdata (assembled),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver; a WRAP=1 twin sees the same stimulus.
module tb_serial_byte_receiver;

  logic       clk = 1'b0;
  logic       clear, serial_in, bit_en, sync;
  logic [3:0] rd_addr;

  logic [7:0] byte_out0, rd_data0, byte_out1, rd_data1;
  logic       byte_valid0, full0, overflow0, byte_valid1, full1, overflow1;
  logic [3:0] wr_addr0, wr_addr1;
  logic [4:0] count0, count1;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  serial_byte_receiver #(.WRAP(0)) dut0 (
    .clk(clk), .clear(clear), .serial_in(serial_in), .bit_en(bit_en), .sync(sync),
    .byte_out(byte_out0), .byte_valid(byte_valid0), .wr_addr(wr_addr0), .count(count0),
    .full(full0), .overflow(overflow0), .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  serial_byte_receiver #(.WRAP(1)) dut1 (
    .clk(clk), .clear(clear), .serial_in(serial_in), .bit_en(bit_en), .sync(sync),
    .byte_out(byte_out1), .byte_valid(byte_valid1), .wr_addr(wr_addr1), .count(count1),
    .full(full1), .overflow(overflow1), .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte monitor: every pulse must match the oldest pending expected byte.
  always @(negedge clk) begin
    if (byte_valid0 === 1'b1) begin
      pulses++;
      if (sb.size() > 0) chk("byte_out_sb", byte_out0, sb.pop_front());
      else               chk("spurious_valid", byte_valid0, 1'b0);
    end
  end

  task automatic drive(input logic en, input logic s, input logic b);
    bit_en = en; sync = s; serial_in = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear(input int cycles);
    clear = 1'b1; bit_en = 1'b0; sync = 1'b0; serial_in = 1'b0;
    for (int i = 0; i < cycles; i++) begin @(posedge clk); #1; end
    clear = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) idle();
      if (i == 7) sb.push_back(v);
      drive(1'b1, 1'b0, v[i]);
    end
  endtask

  task automatic rd(input logic [3:0] a);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    rd_addr = '0;
    do_clear(2);

    // Reset state
    chk("rst_count", count0, 0);
    chk("rst_full", full0, 0);
    chk("rst_overflow", overflow0, 0);
    chk("rst_wr_addr", wr_addr0, 0);
    chk("rst_byte_out", byte_out0, 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk($sformatf("rst_mem%0d", a), rd_data0, 8'h00);
    end
    chk("rst_no_pulse", pulses, 0);

    // Single byte 0xCC
    send_byte(8'hCC, 1'b0);
    chk("cc_valid", byte_valid0, 1);
    chk("cc_byte_out", byte_out0, 8'hCC);
    chk("cc_wr_addr", wr_addr0, 1);
    chk("cc_count", count0, 1);
    idle();
    chk("cc_valid_one_cycle", byte_valid0, 0);
    rd(4'd0);
    chk("cc_mem0", rd_data0, 8'hCC);
    chk("cc_pulses", pulses, 1);

    // Fill with alternating pattern, random gaps
    do_clear(1);
    base = pulses;
    for (int k = 0; k < 16; k++) send_byte((k % 2 == 0) ? 8'hCC : 8'hAA, 1'b1);
    idle();
    chk("fill_pulses", pulses - base, 16);
    chk("fill_full", full0, 1);
    chk("fill_count", count0, 16);
    chk("fill_wr_addr", wr_addr0, 0);
    chk("fill_overflow", overflow0, 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk($sformatf("fill_mem%0d", a), rd_data0, (a % 2 == 0) ? 8'hCC : 8'hAA);
      chk($sformatf("fill_wrap_mem%0d", a), rd_data1, (a % 2 == 0) ? 8'hCC : 8'hAA);
    end

    // One more byte while full
    send_byte(8'h55, 1'b0);
    chk("ovf_valid", byte_valid0, 1);
    chk("ovf_byte_out", byte_out0, 8'h55);
    chk("ovf_flag", overflow0, 1);
    chk("ovf_count", count0, 16);
    chk("ovf_wr_addr", wr_addr0, 0);
    chk("wrap_overflow", overflow1, 0);
    chk("wrap_wr_addr", wr_addr1, 1);
    chk("wrap_count", count1, 16);
    chk("wrap_full", full1, 1);
    rd(4'd0);
    chk("ovf_mem0", rd_data0, 8'hCC);
    chk("wrap_mem0", rd_data1, 8'h55);
    idle(); idle();
    chk("ovf_sticky", overflow0, 1);

    // Sync realign
    do_clear(1);
    base = pulses;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) sb.push_back(8'hFE);
      drive(1'b1, 1'b0, 1'b1);
    end
    chk("sync_byte_out", byte_out0, 8'hFE);
    idle();
    chk("sync_pulses", pulses - base, 1);
    // sync on the completing bit suppresses the byte
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    chk("sync_wins_valid", byte_valid0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) sb.push_back(8'h01);
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("sync_wins_byte_out", byte_out0, 8'h01);
    idle();
    chk("sync_wins_pulses", pulses - base, 2);

    // Reset mid-byte
    do_clear(1);
    base = pulses;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
    do_clear(1);
    send_byte(8'h0F, 1'b0);
    chk("midclr_byte_out", byte_out0, 8'h0F);
    chk("midclr_count", count0, 1);
    idle();
    rd(4'd0);
    chk("midclr_mem0", rd_data0, 8'h0F);
    chk("midclr_pulses", pulses - base, 1);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Receive-side counterpart of the team's memory-backed serial bit transmitter.
- Takes a 1-bit serial stream, LSB first, 8 bits per byte; bit i of each byte arrives on the i-th accepted bit.
- Assembles each byte and writes it into a 16-entry x 8-bit store at an auto-incrementing address.
- The store is readable through a registered read port, so a test harness or downstream logic can compare received data against transmitted data.

Parameters:
- WIDTH, 8, bits per byte; bit counter width is clog2(WIDTH).
- DEPTH, 16, store entries; address width is clog2(DEPTH).
- WRAP, 0, 0 = stop writing when full and flag overflow; 1 = wrap address and overwrite the oldest entry.

Ports:
- clk  in  1  single clock, rising edge.
- clear  in  1  synchronous active-high reset.
- serial_in  in  1  serial data bit, sampled when bit_en=1.
- bit_en  in  1  qualifies serial_in for this cycle.
- sync  in  1  frame realign: discard the partial byte; the next accepted bit is bit 0.
- byte_out  out  WIDTH  last completed byte.
- byte_valid  out  1  one-cycle pulse when byte_out updates.
- wr_addr  out  clog2(DEPTH)  address the next completed byte is written to.
- count  out  clog2(DEPTH)+1  number of stored bytes, saturating at DEPTH.
- full  out  1  high when count==DEPTH.
- overflow  out  1  sticky; set when a byte completes while full and WRAP=0.
- rd_addr  in  clog2(DEPTH)  read address.
- rd_data  out  WIDTH  store[rd_addr], registered, 1-cycle latency.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- On clear=1:
  - bit_cnt, shift register, byte_out, byte_valid, wr_addr, count, full, overflow and rd_data all go to 0.
  - All store entries go to 0.
  - clear has priority over every other input.
- Bit accept (bit_en=1, sync=0): shreg[bit_cnt] <= serial_in; bit_cnt increments mod WIDTH.
- Byte complete (bit_en=1 and bit_cnt==WIDTH-1): next edge updates the following.
  - byte_out <= {serial_in, shreg[WIDTH-2:0]}.
  - byte_valid=1 for exactly one cycle.
  - Latency is 1 cycle from the final bit's sampling edge to byte_valid visibility.
- Store write on byte complete:
  - If not full, or WRAP=1: store[wr_addr] <= assembled byte; wr_addr increments mod DEPTH (15->0); count increments, saturating at DEPTH.
  - If full and WRAP=0: no write; wr_addr and count hold; overflow <= 1. byte_valid and byte_out still update.
- full is combinational from count. With WRAP=1, full stays high after the first DEPTH bytes.
- sync=1:
  - bit_cnt <= 0 and the partial byte is discarded; no byte_valid.
  - If bit_en=1 in the same cycle, that bit is taken as bit 0: shreg[0] <= serial_in, bit_cnt <= 1.
  - sync on the cycle that would complete a byte: the byte is not completed; sync wins.
- bit_en=0: all state holds; byte_valid=0.
- Read port: rd_data <= store[rd_addr] every cycle. A read and write to the same address in the same cycle returns the old contents.
- clear mid-byte: the partial byte is discarded, with no byte_valid and no write.

Decomposition:
- Shared package holds:
  - BYTE_W=8, MEM_DEPTH=16, ADDR_W=4, BITCNT_W=3.
  - Bit order constant LSB_FIRST=1, shared with the transmitter.
- One sub-module: rx_byte_store, the DEPTH x WIDTH register file. It has clear, one write port (we, waddr, wdata) and one registered read port.
- Bit counter, assembly and flags stay in the top module.

Test Plan:
- Reset: hold clear 2 cycles, release, then read rd_addr 0..15 -> every rd_data=0x00; count=0, full=0, overflow=0, byte_valid never pulses.
- Single byte 0xCC:
  - Stimulus: bits 0,0,1,1,0,0,1,1 on 8 consecutive bit_en cycles.
  - Response: byte_valid pulses once, 1 cycle after the 8th bit; byte_out=0xCC; wr_addr=1; count=1; rd_addr=0 -> rd_data=0xCC next cycle.
- Gaps and pattern:
  - Stimulus: alternating 0xCC/0xAA (0xAA = 0,1,0,1,0,1,0,1) for 16 bytes, with bit_en low on random cycles.
  - Response: 16 byte_valid pulses; store[even]=0xCC, store[odd]=0xAA; full=1; count=16; wr_addr=0.
- Overflow, WRAP=0: after the fill above, send 0x55 -> byte_valid pulses, byte_out=0x55, overflow=1 sticky, store[0] stays 0xCC, count=16.
  - Overwrite, WRAP=1: same stimulus -> store[0]=0x55, wr_addr=1, overflow=0.
- Sync realign:
  - Stimulus: 5 bits 1,1,1,1,1, then sync=1 with bit_en=1 and serial_in=0, then 7 more bits 1,1,1,1,1,1,1.
  - Response: one byte_valid only, after the final bit; byte_out=0xFE; no byte for the discarded 5 bits.
- Reset mid-byte: after 4 bits of 0xFF, assert clear 1 cycle, then send 0x0F -> byte_out=0x0F at store[0], count=1, no pulse for the aborted bits.
